fifo_poll_sched: RTL

Round-robin poller that sits directly upstream of the per-channel packet checker/uploader. It walks the 30 channel FIFOs in turn, hands the checker one channel at a time (`start`, channel number, muxed `rdusedw` and `fifo_out`), routes the checker's `rdreq` back to the selected FIFO only, and waits for the checker's `over` before advancing. A watchdog keeps a stalled checker from hanging the poll cycle.

---
 rtl/fifo_poll_sched_pkg.sv | 18 +
 rtl/fifo_poll_sched_ch_mux_demux.sv | 36 +++
 rtl/fifo_poll_sched.sv | 102 ++++++++++
 3 files changed

// File: rtl/fifo_poll_sched_pkg.sv
// Shared definitions for the channel poller and the downstream packet checker:
// FSM state encoding and the default channel/bus geometry.
package fifo_poll_sched_pkg;

  localparam int DEF_NUM_CH  = 30;
  localparam int DEF_USEDW_W = 12;
  localparam int DEF_DATA_W  = 64;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd1,
    S_SEL   = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_NEXT  = 3'd5
  } state_t;

endpackage

// File: rtl/fifo_poll_sched_ch_mux_demux.sv
// Purely combinational channel selector: muxes the selected FIFO's status/data
// to the checker and steers the checker's read request back to that FIFO only.
module ch_mux_demux #(
  parameter int NUM_CH  = 30,
  parameter int USEDW_W = 12,
  parameter int DATA_W  = 64,
  parameter int CH_W    = $clog2(NUM_CH + 1)
) (
  input  logic [CH_W-1:0]           i_ch,
  input  logic                      i_wait,
  input  logic                      i_rdreq,
  input  logic [NUM_CH*USEDW_W-1:0] i_rdusedw_bus,
  input  logic [NUM_CH*DATA_W-1:0]  i_fifo_out_bus,
  output logic [31:0]               o_tongdao,
  output logic [USEDW_W-1:0]        o_rdusedw,
  output logic [DATA_W-1:0]         o_fifo_out,
  output logic [NUM_CH-1:0]         o_rdreq_bus
);

  assign o_tongdao = 32'(i_ch);

  // Channels are numbered from 1, so channel k lives in slice k-1.
  always_comb begin
    o_rdusedw   = '0;
    o_fifo_out  = '0;
    o_rdreq_bus = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (i_ch == CH_W'(k + 1)) begin
        o_rdusedw      = i_rdusedw_bus[k*USEDW_W +: USEDW_W];
        o_fifo_out     = i_fifo_out_bus[k*DATA_W +: DATA_W];
        o_rdreq_bus[k] = i_rdreq & i_wait;
      end
    end
  end

endmodule

// File: rtl/fifo_poll_sched.sv
// Round-robin poller: hands the checker one channel FIFO at a time, waits for
// its completion pulse (or a watchdog abort) and advances to the next channel.
module fifo_poll_sched
  import fifo_poll_sched_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int USEDW_W = DEF_USEDW_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUM_CH*USEDW_W-1:0] rdusedw_bus,
  input  logic [NUM_CH*DATA_W-1:0]  fifo_out_bus,
  output logic [NUM_CH-1:0]         rdreq_bus,
  output logic                      start,
  output logic [31:0]               tongdao,
  output logic [USEDW_W-1:0]        rdusedw,
  output logic [DATA_W-1:0]         fifo_out,
  input  logic                      rdreq,
  input  logic                      over,
  output logic                      round_done,
  output logic                      timeout_err
);

  localparam int CH_W = $clog2(NUM_CH + 1);
  localparam int WD_W = $clog2(TIMEOUT);

  state_t            r_state;
  state_t            w_next;
  logic [CH_W-1:0]   r_ch;
  logic [WD_W-1:0]   r_wd;
  logic              r_start;
  logic              r_round_done;
  logic              r_timeout_err;
  logic              w_expired;
  logic              w_wrap;

  assign w_expired = (r_wd == WD_W'(TIMEOUT - 1));
  assign w_wrap    = (r_ch == CH_W'(NUM_CH));

  // Enable is only sampled in IDLE and NEXT, so a channel in flight always completes.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_next = S_SEL;
      S_SEL:   w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT:  if (over || w_expired) w_next = S_NEXT;
      S_NEXT:  w_next = enable ? S_SEL : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_ch          <= CH_W'(1);
      r_wd          <= '0;
      r_start       <= 1'b0;
      r_round_done  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_start       <= (w_next == S_START);
      r_round_done  <= (w_next == S_NEXT) && w_wrap;
      // over arriving on the expiry cycle takes precedence over the abort.
      r_timeout_err <= (r_state == S_WAIT) && !over && w_expired;
      if (r_state == S_START) begin
        r_wd <= '0;
      end else if (r_state == S_WAIT && w_next == S_WAIT) begin
        r_wd <= r_wd + WD_W'(1);
      end
      if (r_state == S_NEXT) begin
        r_ch <= w_wrap ? CH_W'(1) : r_ch + CH_W'(1);
      end
    end
  end

  assign start       = r_start;
  assign round_done  = r_round_done;
  assign timeout_err = r_timeout_err;

  ch_mux_demux #(
    .NUM_CH  (NUM_CH),
    .USEDW_W (USEDW_W),
    .DATA_W  (DATA_W),
    .CH_W    (CH_W)
  ) u_ch_mux_demux (
    .i_ch           (r_ch),
    .i_wait         (r_state == S_WAIT),
    .i_rdreq        (rdreq),
    .i_rdusedw_bus  (rdusedw_bus),
    .i_fifo_out_bus (fifo_out_bus),
    .o_tongdao      (tongdao),
    .o_rdusedw      (rdusedw),
    .o_fifo_out     (fifo_out),
    .o_rdreq_bus    (rdreq_bus)
  );

endmodule
